// File: rtl/fifo_rr_scheduler.sv
// Round-robin packet scheduler for a bank of show-ahead ingress FIFOs.
// Holds a grant for a whole packet, then rotates priority past the served FIFO.
//
// state | meaning
// IDLE  | no grant; search for a non-empty FIFO starting at rr_ptr
// GRANT | FIFO selected, one settle cycle for the data mux, no pop
// XFER  | pop one word per cycle while ready and non-empty, until EOP or watchdog
module fifo_rr_scheduler #(
  parameter int PORT_NUM      = 16,
  parameter int MAX_PKT_WORDS = 2048
) (
  input  logic                glb_clk,
  input  logic                glb_reset,
  input  logic [PORT_NUM-1:0] fifo_nempty,
  input  logic [PORT_NUM-1:0] fifo_head_eop,
  input  logic                out_ready,
  output logic [PORT_NUM-1:0] fifo_rd_en,
  output logic [7:0]          fifo_sel_res,
  output logic                out_valid,
  output logic                out_eop,
  output logic                pkt_done,
  output logic                pkt_err,
  output logic                busy
);

  localparam int IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int CNT_W = $clog2(MAX_PKT_WORDS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PORT_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sel, sel_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] pick, sel_inc;
  logic             found;
  logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
  logic [7:0]       sel_res_nxt;
  logic             done_nxt, err_nxt;
  logic             pop;

  // Rotating first-set search beginning at rr_ptr
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = rr_ptr;
    idx   = 0;
    for (int i = 0; i < PORT_NUM; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= PORT_NUM) idx = idx - PORT_NUM;
      if (!found && fifo_nempty[idx]) begin
        found = 1'b1;
        pick  = idx[IDX_W-1:0];
      end
    end
  end

  assign sel_inc = (sel == LAST_IDX) ? '0 : sel + 1'b1;

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    rr_ptr_nxt   = rr_ptr;
    word_cnt_nxt = word_cnt;
    sel_res_nxt  = fifo_sel_res;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    pop          = 1'b0;
    fifo_rd_en   = '0;
    out_eop      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          sel_nxt      = pick;
          sel_res_nxt  = 8'd128 | 8'(pick);
          word_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end
      GRANT: state_nxt = XFER;
      XFER: begin
        pop             = out_ready & fifo_nempty[sel];
        fifo_rd_en[sel] = pop;
        out_eop         = pop & fifo_head_eop[sel];
        if (pop) begin
          word_cnt_nxt = word_cnt + 1'b1;
          // EOP wins over the watchdog on the last allowed word
          if (fifo_head_eop[sel] || word_cnt == CNT_LAST) begin
            done_nxt    = fifo_head_eop[sel];
            err_nxt     = ~fifo_head_eop[sel];
            rr_ptr_nxt  = sel_inc;
            sel_res_nxt = 8'd0;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = pop;
  assign busy      = (state != IDLE);

  always_ff @(posedge glb_clk) begin
    if (glb_reset) begin
      state        <= IDLE;
      sel          <= '0;
      rr_ptr       <= '0;
      word_cnt     <= '0;
      fifo_sel_res <= 8'd0;
      pkt_done     <= 1'b0;
      pkt_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      sel          <= sel_nxt;
      rr_ptr       <= rr_ptr_nxt;
      word_cnt     <= word_cnt_nxt;
      fifo_sel_res <= sel_res_nxt;
      pkt_done     <= done_nxt;
      pkt_err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: FIFO contents kept as per-port word lists, an
// ownership-level model predicts every output each cycle, plus literal grant/pop checks.
module tb_fifo_rr_scheduler;
  localparam int N    = 16;
  localparam int MAXW = 8;

  logic          glb_clk = 1'b0;
  logic          glb_reset = 1'b1;
  logic [N-1:0]  fifo_nempty, fifo_head_eop;
  logic          out_ready;
  logic [N-1:0]  fifo_rd_en;
  logic [7:0]    fifo_sel_res;
  logic          out_valid, out_eop, pkt_done, pkt_err, busy;

  fifo_rr_scheduler #(.PORT_NUM(N), .MAX_PKT_WORDS(MAXW)) dut (
    .glb_clk(glb_clk), .glb_reset(glb_reset),
    .fifo_nempty(fifo_nempty), .fifo_head_eop(fifo_head_eop),
    .out_ready(out_ready), .fifo_rd_en(fifo_rd_en),
    .fifo_sel_res(fifo_sel_res), .out_valid(out_valid), .out_eop(out_eop),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .busy(busy)
  );

  always #5 glb_clk = ~glb_clk;

  // FIFO contents: eop flag per stored word
  bit fq_eop [N][64];
  int fq_head [N];
  int fq_tail [N];
  logic [N-1:0] mask_off;

  // Model: who owns the output, whether the settle cycle is pending
  int m_owner = -1;
  bit m_settle, m_done, m_err;
  int m_rr, m_cnt;

  int n_tests, n_fail;
  bit check_en;
  int grant_log[$];
  bit prev_nz;
  int pop_cnt [N];
  int done_cnt, err_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int p, input int words, input bit last_eop);
    for (int w = 0; w < words; w++) begin
      fq_eop[p][fq_tail[p]] = last_eop && (w == words - 1);
      fq_tail[p]++;
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < N; p++) begin
      fifo_nempty[p]   = (fq_tail[p] > fq_head[p]) && !mask_off[p];
      fifo_head_eop[p] = (fq_tail[p] > fq_head[p]) ? fq_eop[p][fq_head[p]] : 1'b0;
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    for (int p = 0; p < N; p++) pop_cnt[p] = 0;
  endtask

  task automatic cycle();
    logic         exp_pop, exp_eop;
    logic [N-1:0] exp_rd;
    logic [7:0]   exp_sel;
    int           p;
    drive_inputs();
    @(negedge glb_clk);
    exp_pop = 1'b0;
    exp_eop = 1'b0;
    exp_rd  = '0;
    if (m_owner >= 0 && !m_settle) begin
      exp_pop = out_ready && fifo_nempty[m_owner];
      exp_eop = exp_pop && fifo_head_eop[m_owner];
      exp_rd[m_owner] = exp_pop;
    end
    exp_sel = (m_owner < 0) ? 8'd0 : 8'(128 + m_owner);
    if (check_en) begin
      chk("rd_en", fifo_rd_en, exp_rd);
      chk("sel_res", fifo_sel_res, exp_sel);
      chk("out_valid", out_valid, exp_pop);
      chk("out_eop", out_eop, exp_eop);
      chk("pkt_done", pkt_done, m_done);
      chk("pkt_err", pkt_err, m_err);
      chk("busy", busy, m_owner >= 0);
    end
    if (fifo_sel_res != 0 && !prev_nz) grant_log.push_back(int'(fifo_sel_res));
    prev_nz = (fifo_sel_res != 0);
    for (int k = 0; k < N; k++) if (fifo_rd_en[k]) pop_cnt[k]++;
    done_cnt += int'(pkt_done);
    err_cnt  += int'(pkt_err);

    m_done = 1'b0;
    m_err  = 1'b0;
    if (exp_pop) fq_head[m_owner]++;
    if (glb_reset) begin
      m_owner = -1; m_settle = 1'b0; m_rr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        p = (m_rr + k) % N;
        if (m_owner < 0 && fifo_nempty[p]) begin
          m_owner = p; m_settle = 1'b1; m_cnt = 0;
        end
      end
    end else if (m_settle) begin
      m_settle = 1'b0;
    end else if (exp_pop) begin
      m_cnt++;
      if (exp_eop || m_cnt == MAXW) begin
        m_done  = exp_eop;
        m_err   = !exp_eop;
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    @(posedge glb_clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Per-cycle stimulus for the stall test
  bit t4_ready [16] = '{1,1,1,0,0,1,1,1,1,1,1,1,1,1,1,1};
  bit t4_mask  [16] = '{0,0,0,0,0,1,1,0,0,0,0,0,0,0,0,0};

  initial begin
    int d0, e0;
    bit reached;
    out_ready = 1'b1;
    mask_off  = '0;
    drive_inputs();
    @(posedge glb_clk);
    #1;
    check_en = 1'b1;
    cycle();
    glb_reset = 1'b0;

    // 1: idle with nothing pending
    run(10);
    chk("t1_grants", grant_log.size(), 0);
    chk("t1_busy", busy, 1'b0);

    // 2: 4-word packet on FIFO3, then rr_ptr=4 picks 5 before 2
    clear_logs();
    push_pkt(3, 4, 1'b1);
    run(8);
    chk("t2_pops3", pop_cnt[3], 4);
    chk("t2_done", done_cnt, 1);
    push_pkt(2, 1, 1'b1);
    push_pkt(5, 1, 1'b1);
    run(10);
    chk("t2_g0", grant_log[0], 131);
    chk("t2_g1", grant_log[1], 133);
    chk("t2_g2", grant_log[2], 130);

    // 3: wrap order after reset
    glb_reset = 1'b1;
    cycle();
    glb_reset = 1'b0;
    clear_logs();
    push_pkt(0, 1, 1'b1);
    push_pkt(5, 1, 1'b1);
    push_pkt(15, 1, 1'b1);
    run(12);
    push_pkt(0, 1, 1'b1);
    run(5);
    chk("t3_n", grant_log.size(), 4);
    chk("t3_g0", grant_log[0], 128);
    chk("t3_g1", grant_log[1], 133);
    chk("t3_g2", grant_log[2], 143);
    chk("t3_g3", grant_log[3], 128);

    // 4: stalls on ready and empty, FIFO7 waits
    clear_logs();
    push_pkt(2, 4, 1'b1);
    push_pkt(7, 1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      out_ready   = t4_ready[i];
      mask_off[2] = t4_mask[i];
      cycle();
      if (i == 6) chk("t4_hold", fifo_sel_res, 130);
    end
    out_ready = 1'b1;
    mask_off  = '0;
    chk("t4_pops2", pop_cnt[2], 4);
    chk("t4_g0", grant_log[0], 130);
    chk("t4_g1", grant_log[1], 135);

    // 5: watchdog on a runaway packet from the only requester
    clear_logs();
    d0 = done_cnt;
    e0 = err_cnt;
    push_pkt(1, 12, 1'b0);
    run(20);
    chk("t5_err", err_cnt - e0, 1);
    chk("t5_pops1", pop_cnt[1], 12);
    chk("t5_regrant", grant_log.size() == 2 ? grant_log[1] : 0, 129);
    push_pkt(1, 1, 1'b1);
    run(4);
    chk("t5_done", done_cnt - d0, 1);

    // 6: reset during word 2 of a 5-word packet
    clear_logs();
    d0 = done_cnt;
    e0 = err_cnt;
    push_pkt(9, 5, 1'b1);
    reached = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_owner == 9 && !m_settle && m_cnt == 1) begin
        reached = 1'b1;
        break;
      end
      cycle();
    end
    chk("t6_reach", reached, 1'b1);
    glb_reset = 1'b1;
    cycle();
    glb_reset = 1'b0;
    chk("t6_sel", fifo_sel_res, 0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_rd", fifo_rd_en, 0);
    push_pkt(3, 1, 1'b1);
    run(14);
    chk("t6_noerr", err_cnt - e0, 0);
    chk("t6_done", done_cnt - d0, 2);
    chk("t6_g1", grant_log.size() >= 3 ? grant_log[1] : 0, 131);
    chk("t6_g2", grant_log.size() >= 3 ? grant_log[2] : 0, 137);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
